clint: RTL and testbench

//  Core-local interrupt/trap sequencer. It watches the instruction in ID for ecall/ebreak/mret and samples external

---
 rtl/clint.sv | 196 +++++++++++++++++++
 tb/tb_clint.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// Core-local interrupt/trap sequencer: ecall/ebreak/mret and external IRQ entry via a CSR write port.
// Optional CLINT_VECTORED_EN macro enables vectored mtvec targets for asynchronous traps.
module clint #(
  parameter int          INT_WIDTH   = 8,
  parameter logic [31:0] ASYNC_CAUSE = 32'h8000_0010
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          inst_i,
  input  logic [31:0]          inst_addr_i,
  input  logic                 jump_en_i,
  input  logic [31:0]          jump_addr_i,
  input  logic [INT_WIDTH-1:0] int_flag_i,
  input  logic [31:0]          csr_mtvec_i,
  input  logic [31:0]          csr_mepc_i,
  input  logic [31:0]          csr_mstatus_i,
  output logic                 we_o,
  output logic [11:0]          waddr_o,
  output logic [31:0]          wdata_o,
  output logic                 hold_flag_o,
  output logic                 int_assert_o,
  output logic [31:0]          int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MSTATUS,
    S_MCAUSE,
    S_MRET
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        async_q, async_d;

  logic        we_d, int_assert_d;
  logic [11:0] waddr_d;
  logic [31:0] wdata_d, int_addr_d;

  logic        is_ecall, is_ebreak, is_mret, irq_take;
  logic [31:0] irq_idx;
  logic [31:0] trap_base, trap_target;
  logic [31:0] mst_trap, mst_mret;
  logic        hold;

  // Wrong-path instructions behind an EX redirect must not trap.
  assign is_ecall  = !jump_en_i && (inst_i == INST_ECALL);
  assign is_ebreak = !jump_en_i && (inst_i == INST_EBREAK);
  assign is_mret   = !jump_en_i && (inst_i == INST_MRET);
  assign irq_take  = (|int_flag_i) && csr_mstatus_i[3];

  always_comb begin
    irq_idx = '0;
    for (int i = INT_WIDTH - 1; i >= 0; i--) begin
      if (int_flag_i[i]) irq_idx = 32'(i);
    end
  end

  assign trap_base = {csr_mtvec_i[31:2], 2'b00};

`ifdef CLINT_VECTORED_EN
  assign trap_target = (async_q && csr_mtvec_i[1:0] == 2'b01)
                     ? trap_base + {cause_q[29:0], 2'b00}
                     : trap_base;
`else
  logic unused_vec;
  assign unused_vec  = ^{async_q, csr_mtvec_i[1:0]};
  assign trap_target = trap_base;
`endif

  always_comb begin
    mst_trap    = csr_mstatus_i;
    mst_trap[7] = csr_mstatus_i[3];
    mst_trap[3] = 1'b0;
    mst_mret    = csr_mstatus_i;
    mst_mret[3] = csr_mstatus_i[7];
    mst_mret[7] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    async_d      = async_q;
    hold         = 1'b0;
    we_d         = 1'b0;
    waddr_d      = '0;
    wdata_d      = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (is_mret) begin
          state_d = S_MRET;
          hold    = 1'b1;
        end else if (is_ecall || is_ebreak) begin
          epc_d   = inst_addr_i;
          cause_d = is_ecall ? 32'd11 : 32'd3;
          async_d = 1'b0;
          state_d = S_MEPC;
          hold    = 1'b1;
        end else if (irq_take) begin
          epc_d   = jump_en_i ? jump_addr_i : inst_addr_i;
          cause_d = ASYNC_CAUSE + irq_idx;
          async_d = 1'b1;
          state_d = S_MEPC;
          hold    = 1'b1;
        end
      end
      S_MEPC: begin
        state_d = S_MSTATUS;
        hold    = 1'b1;
      end
      S_MSTATUS: begin
        state_d = S_MCAUSE;
        hold    = 1'b1;
      end
      S_MCAUSE: begin
        state_d = S_IDLE;
        hold    = 1'b1;
      end
      S_MRET: begin
        state_d = S_IDLE;
        hold    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are computed from the state being entered.
    case (state_d)
      S_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        wdata_d = epc_d;
      end
      S_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        wdata_d = mst_trap;
      end
      S_MCAUSE: begin
        we_d         = 1'b1;
        waddr_d      = CSR_MCAUSE;
        wdata_d      = cause_q;
        int_assert_d = 1'b1;
        int_addr_d   = trap_target;
      end
      S_MRET: begin
        we_d         = 1'b1;
        waddr_d      = CSR_MSTATUS;
        wdata_d      = mst_mret;
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      async_q      <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      async_q      <= async_d;
      we_o         <= we_d;
      waddr_o      <= waddr_d;
      wdata_o      <= wdata_d;
      int_assert_o <= int_assert_d;
      int_addr_o   <= int_addr_d;
    end
  end

  assign hold_flag_o = hold;

endmodule

// File: tb/tb_clint.sv
// Directed-vector bench for clint; expected values are hand-computed.
module tb_clint;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic [7:0]  int_flag_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        we_o;
  logic [11:0] waddr_o;
  logic [31:0] wdata_o;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  int vectors;
  int miscompares;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

`ifdef CLINT_VECTORED_EN
  localparam logic [31:0] VEC_ADDR = 32'h0000_0840;
`else
  localparam logic [31:0] VEC_ADDR = 32'h0000_0800;
`endif

  clint #(.INT_WIDTH(8), .ASYNC_CAUSE(32'h8000_0010)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .int_flag_i    (int_flag_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .csr_mstatus_i (csr_mstatus_i),
    .we_o          (we_o),
    .waddr_o       (waddr_o),
    .wdata_o       (wdata_o),
    .hold_flag_o   (hold_flag_o),
    .int_assert_o  (int_assert_o),
    .int_addr_o    (int_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet_inputs();
    inst_i     = NOP;
    jump_en_i  = 1'b0;
    int_flag_i = '0;
  endtask

  task automatic check_idle(input string tag);
    #1;
    check_vec({tag, ".we"},     {31'd0, we_o},         32'd0);
    check_vec({tag, ".assert"}, {31'd0, int_assert_o}, 32'd0);
    check_vec({tag, ".hold"},   {31'd0, hold_flag_o},  32'd0);
  endtask

  // Called with the triggering stimulus already applied in the detect cycle.
  task automatic run_trap(input string tag, input logic [31:0] epc, input logic [31:0] mst,
                          input logic [31:0] cause, input logic [31:0] target);
    #1;
    check_vec({tag, ".det_hold"}, {31'd0, hold_flag_o}, 32'd1);
    check_vec({tag, ".det_we"},   {31'd0, we_o},        32'd0);
    tick();
    quiet_inputs();
    #1;
    check_vec({tag, ".mepc_we"},   {31'd0, we_o},        32'd1);
    check_vec({tag, ".mepc_addr"}, {20'd0, waddr_o},     32'h341);
    check_vec({tag, ".mepc_dat"},  wdata_o,              epc);
    check_vec({tag, ".mepc_hold"}, {31'd0, hold_flag_o}, 32'd1);
    tick();
    #1;
    check_vec({tag, ".mst_addr"},   {20'd0, waddr_o},      32'h300);
    check_vec({tag, ".mst_dat"},    wdata_o,               mst);
    check_vec({tag, ".mst_assert"}, {31'd0, int_assert_o}, 32'd0);
    check_vec({tag, ".mst_hold"},   {31'd0, hold_flag_o},  32'd1);
    tick();
    #1;
    check_vec({tag, ".mc_we"},     {31'd0, we_o},         32'd1);
    check_vec({tag, ".mc_addr"},   {20'd0, waddr_o},      32'h342);
    check_vec({tag, ".mc_dat"},    wdata_o,               cause);
    check_vec({tag, ".mc_assert"}, {31'd0, int_assert_o}, 32'd1);
    check_vec({tag, ".mc_target"}, int_addr_o,            target);
    check_vec({tag, ".mc_hold"},   {31'd0, hold_flag_o},  32'd1);
    tick();
    check_idle({tag, ".end"});
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    inst_addr_i   = '0;
    jump_addr_i   = '0;
    csr_mtvec_i   = 32'h800;
    csr_mepc_i    = '0;
    csr_mstatus_i = '0;
    quiet_inputs();

    tick();
    #1;
    check_vec("rst.we",       {31'd0, we_o},         32'd0);
    check_vec("rst.waddr",    {20'd0, waddr_o},      32'd0);
    check_vec("rst.wdata",    wdata_o,               32'd0);
    check_vec("rst.assert",   {31'd0, int_assert_o}, 32'd0);
    check_vec("rst.int_addr", int_addr_o,            32'd0);
    check_vec("rst.hold",     {31'd0, hold_flag_o},  32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ecall at 0x100
    inst_i = ECALL; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h800;
    run_trap("ecall", 32'h100, 32'h80, 32'd11, 32'h800);

    // ebreak with MIE=0 still traps; MPIE becomes 0
    inst_i = EBREAK; inst_addr_i = 32'h180; csr_mstatus_i = 32'h0;
    run_trap("ebreak", 32'h180, 32'h0, 32'd3, 32'h800);

    // mret wins over a concurrent interrupt request
    inst_i = MRET; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h80; int_flag_i = 8'h01;
    #1;
    check_vec("mret.det_hold", {31'd0, hold_flag_o}, 32'd1);
    tick();
    quiet_inputs();
    #1;
    check_vec("mret.we",     {31'd0, we_o},         32'd1);
    check_vec("mret.addr",   {20'd0, waddr_o},      32'h300);
    check_vec("mret.dat",    wdata_o,               32'h88);
    check_vec("mret.assert", {31'd0, int_assert_o}, 32'd1);
    check_vec("mret.target", int_addr_o,            32'h104);
    check_vec("mret.hold",   {31'd0, hold_flag_o},  32'd1);
    tick();
    check_idle("mret.end");

    // async, lines 1 and 2 pending: line 1 wins
    inst_addr_i = 32'h200; csr_mstatus_i = 32'h8; int_flag_i = 8'b0000_0110;
    run_trap("irq", 32'h200, 32'h80, 32'h8000_0011, 32'h800);

    // async masked by MIE=0
    csr_mstatus_i = 32'h0; int_flag_i = 8'b0000_0110;
    check_idle("irq_masked.c0");
    tick();
    check_idle("irq_masked.c1");
    quiet_inputs();

    // ecall on the wrong path
    inst_i = ECALL; jump_en_i = 1'b1; jump_addr_i = 32'h300; csr_mstatus_i = 32'h8;
    check_idle("ecall_jump.c0");
    tick();
    check_idle("ecall_jump.c1");

    // async during a redirect: epc from jump target; mtvec mode bits set
    inst_i = ECALL; jump_en_i = 1'b1; jump_addr_i = 32'h300; inst_addr_i = 32'h400;
    int_flag_i = 8'h01; csr_mtvec_i = 32'h801; csr_mstatus_i = 32'h8;
    run_trap("irq_jump", 32'h300, 32'h80, 32'h8000_0010, VEC_ADDR);

    // reset during the MSTATUS cycle aborts the sequence
    csr_mtvec_i = 32'h800; csr_mstatus_i = 32'h8; inst_i = ECALL; inst_addr_i = 32'h100;
    tick();
    quiet_inputs();
    tick();
    #1;
    check_vec("rstmid.pre_we",   {31'd0, we_o},     32'd1);
    check_vec("rstmid.pre_addr", {20'd0, waddr_o},  32'h300);
    rst_n = 1'b0;
    #1;
    check_vec("rstmid.we",     {31'd0, we_o},         32'd0);
    check_vec("rstmid.assert", {31'd0, int_assert_o}, 32'd0);
    check_vec("rstmid.hold",   {31'd0, hold_flag_o},  32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("rstmid.after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
